// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the single-outstanding imem
// handshake and hands one instruction at a time to decode. Optional: FETCH_MISALIGN_CHK_EN.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic [31:0] pc,
  output logic        misalign
);

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic [2:0] {BOOT, REQ, WAIT, OUT, HALT} state_e;
`else
  typedef enum logic [1:0] {BOOT, REQ, WAIT, OUT} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] redir_pc;
  logic        halted;

`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_q, misalign_d;
  logic        redir_bad;

  assign redir_pc  = redir_target;
  assign redir_bad = |redir_target[1:0];
  assign halted    = (state_q == HALT);
  assign misalign  = misalign_q;
`else
  // Without the check, low target bits are simply dropped.
  logic [1:0]  unused_tgt_lo;

  assign unused_tgt_lo = redir_target[1:0];
  assign redir_pc      = {redir_target[31:2], 2'b00};
  assign halted        = 1'b0;
  assign misalign      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    if_pc_d = if_pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_d = misalign_q;
`endif

    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d  = imem_rdata;
            if_pc_d = pc_q;
            pc_d    = pc_q + 32'd4;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (id_ready) state_d = REQ;
      end
`ifdef FETCH_MISALIGN_CHK_EN
      HALT: state_d = HALT;
`endif
      default: state_d = BOOT;
    endcase

    // Redirect overrides the sequential update; the in-flight or held
    // instruction belongs to the wrong path and is dropped or killed.
    if (redir_valid && !halted) begin
      pc_d = redir_pc;
      case (state_q)
        BOOT: state_d = REQ;
        REQ: begin
          if (imem_gnt) kill_d = 1'b1;
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_d = REQ;
            kill_d  = 1'b0;
            inst_d  = inst_q;
            if_pc_d = if_pc_q;
          end else begin
            kill_d = 1'b1;
          end
        end
        OUT: state_d = REQ;
        default: ;
      endcase
`ifdef FETCH_MISALIGN_CHK_EN
      if (redir_bad) begin
        state_d    = HALT;
        kill_d     = 1'b0;
        misalign_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      inst_q  <= NOP_INST;
      if_pc_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      if_pc_q <= if_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`endif

  // Outputs depend only on state and registers, never directly on inputs.
  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign if_valid  = (state_q == OUT);
  assign if_inst   = (state_q == OUT) ? inst_q : NOP_INST;
  assign if_pc     = if_pc_q;

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Multi-cycle instruction-fetch sequencer that owns the architectural PC register and drives the instruction-memory request/response handshake. The next-PC value computed in execute arrives here as a redirect. The block presents one fetched instruction at a time to decode through a valid/ready pair. It sits between the PC/next-PC datapath and decode, and kills wrong-path fetches on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
NOP_INST, 32'h0000_0013, value driven on if_inst whenever if_valid=0 (addi x0,x0,0).

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch address; equals pc_q.
imem_gnt  in  1  memory accepts request this cycle (imem_req & imem_gnt = handshake).
imem_rvalid  in  1  response valid; at most one outstanding request.
imem_rdata  in  32  response instruction word.
redir_valid  in  1  redirect strobe from execute (taken branch/jump).
redir_target  in  32  redirect PC (next-PC datapath output).
if_valid  out  1  instruction valid to decode.
if_inst  out  32  instruction word.
if_pc  out  32  address the instruction was fetched from.
id_ready  in  1  decode accepts (if_valid & id_ready = handshake).
pc  out  32  current fetch PC (pc_q), for debug/trace.
misalign  out  1  sticky misaligned-target flag (optional feature only; 0 otherwise).

Behaviour:
- Reset (async, rst_n=0): state=BOOT, pc_q=RESET_PC, kill_q=0, imem_req=0, if_valid=0, if_inst=NOP_INST, if_pc=0, misalign=0. Outputs take reset values immediately, without waiting for a clock edge. Reset mid-transaction abandons any outstanding request; any later imem_rvalid is ignored while in BOOT.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- States:
  - BOOT: imem_req=0. Go to REQ next cycle.
  - REQ: imem_req=1, imem_addr=pc_q. On imem_gnt go to WAIT; otherwise stay in REQ.
  - WAIT: imem_req=0. On imem_rvalid with kill_q=0: latch if_inst=imem_rdata and if_pc=pc_q, set pc_q=pc_q+4 (wraps modulo 2^32), go to OUT. On imem_rvalid with kill_q=1: discard the data, clear kill_q, go to REQ.
  - OUT: if_valid=1. On id_ready: clear if_valid, go to REQ.
- if_inst and if_pc are held stable while if_valid=1 and id_ready=0.
- Redirect handling (redir_valid=1). pc_q<=redir_target in every case; redirect has priority over the +4 update. Per state:
  - BOOT: go to REQ.
  - REQ without gnt: stay in REQ; the new address is presented next cycle. Changing the address before grant is legal.
  - REQ with gnt: go to WAIT and set kill_q=1.
  - WAIT without rvalid: set kill_q=1.
  - WAIT with rvalid: discard the data, go to REQ.
  - OUT: if_valid=0 next cycle, go to REQ; the instruction is dropped even if id_ready=1 in the same cycle.
- Back-to-back redirects: the last one wins. kill_q is a single bit, which is sufficient because at most one request is outstanding.
- Latency: redirect to imem_req with new address = 1 cycle. Grant to if_valid = response latency + 1 cycle. Minimum 3 cycles per instruction with zero-wait memory.

Optional Feature:
FETCH_MISALIGN_CHK_EN
- Defined: a redirect with redir_target[1:0]!=0 sets misalign=1 (sticky until reset) and moves the block to HALT. In HALT: imem_req=0, if_valid=0, pc_q=the offending target; redirects and responses are ignored.
- Undefined: no HALT state. redir_target[1:0] is forced to 2'b00 when loaded into pc_q. misalign is tied to 0.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory (gnt=1, rvalid one cycle after grant), id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; if_valid pulses every 3 cycles with matching if_pc; pc wraps 0xFFFF_FFFC -> 0x0.
- Decode stall: id_ready=0 for 5 cycles while if_valid=1 -> if_inst/if_pc held constant, imem_req=0; release -> REQ at the next pc.
- Redirect to 0x100 in WAIT before rvalid, then a response 0xDEADBEEF -> response dropped (if_valid stays 0); next imem_addr=0x100; if_pc=0x100 on the following delivery.
- Redirect to 0x200 in REQ with gnt=0, then gnt after 2 cycles -> imem_addr=0x200 from the cycle after the redirect; no kill; the delivered instruction has if_pc=0x200.
- Redirect to 0x40 while in OUT with id_ready=1 in the same cycle -> instruction not delivered, if_valid=0 next cycle, next imem_addr=0x40.
- With FETCH_MISALIGN_CHK_EN: redirect to 0x102 -> misalign=1, imem_req=0 forever, pc=0x102; rst_n low mid-HALT -> all outputs return to reset values asynchronously.
